dmem_responder: RTL and testbench

Memory-side responder for the pipeline's data-memory port. Accepts one load/store request at a time from the memory stage over a valid/ready handshake, inserts a configurable number of wait states, performs the access on an internal word-addressed array, and returns read data with a one-cycle response pulse. It also raises `busy` for the future stall engine. That gives the pipeline a multi-cycle memory to stall against, replacing the always-selected single-cycle memory.

---
 rtl/dmem_responder.sv | 196 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the pipeline data-memory port. It accepts one
//   load/store at a time over a valid/ready handshake and waits WAIT_CYCLES
//   wait states. It then accesses an internal word-addressed array and
//   returns a one-cycle response pulse.
//
// Parameters
//   ADDR_W      : word-address width, array depth is 2**ADDR_W 32-bit words
//   WAIT_CYCLES : wait states between acceptance and access (0..15)
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_we                   : 1 = store, 0 = load
//   req_addr, req_wdata      : byte address, store data
//   req_be                   : store byte enables (ignored on loads)
//   resp_valid               : one-cycle response pulse
//   resp_rdata, resp_err     : load data (0 for stores/errors), error flag
//   busy                     : registered, high while a request waits
module dmem_responder #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
   localparam int unsigned DEPTH   = 1 << ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic        busy_q, busy_d;

   logic [31:0] mem_q [DEPTH];

   logic              accept;
   logic              acc_en;
   logic              acc_we;
   logic              acc_err;
   logic [31:0]       acc_addr;
   logic [31:0]       acc_wdata;
   logic [3:0]        acc_be;
   logic [ADDR_W-1:0] acc_idx;

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         busy_q       <= busy_d;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   assign accept = req_valid && (state_q != ST_WAIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      unique case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = WAIT_LD;
               state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Access selection: with zero wait states the access uses the request
   // being accepted on this edge; otherwise it uses the latched request.
   // ---------------------------------------------------------------
   always_comb begin
      acc_en    = 1'b0;
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      if (accept && (WAIT_CYCLES == 0)) begin
         acc_en    = 1'b1;
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end else if ((state_q == ST_WAIT) && (cnt_q == 4'd1)) begin
         acc_en = 1'b1;
      end
   end

   // Misaligned, or any address bit above the array's range set.
   assign acc_err = (acc_addr[1:0] != 2'b00) ||
                    ((acc_addr >> (ADDR_W + 2)) != 32'd0);
   assign acc_idx = acc_addr[ADDR_W+1:2];

   // Response registers: loaded on the access edge, cleared on every other
   // edge so the pulse lasts exactly one cycle.
   always_comb begin
      resp_valid_d = acc_en;
      resp_err_d   = acc_en && acc_err;
      resp_rdata_d = '0;
      if (acc_en && !acc_we && !acc_err) begin
         resp_rdata_d = mem_q[acc_idx];
      end
      busy_d = (state_d == ST_WAIT);
   end

   // Array write; no reset on contents. A reset held across an edge
   // suppresses any write on that edge.
   always_ff @(posedge clk) begin
      if (!rst && acc_en && acc_we && !acc_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------
   always_comb begin
      req_ready  = (state_q != ST_WAIT);
      resp_valid = resp_valid_q;
      resp_rdata = resp_rdata_q;
      resp_err   = resp_err_q;
      busy       = busy_q;
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;

   // Instance A: WAIT_CYCLES = 2
   logic        a_valid, a_we, a_ready, a_rvalid, a_err, a_busy;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [3:0]  a_be;
   // Instance B: WAIT_CYCLES = 0
   logic        b_valid, b_we, b_ready, b_rvalid, b_err, b_busy;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic [3:0]  b_be;

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr),
      .req_wdata(a_wdata), .req_be(a_be), .req_ready(a_ready),
      .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err),
      .busy(a_busy)
   );

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
      .req_wdata(b_wdata), .req_be(b_be), .req_ready(b_ready),
      .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err),
      .busy(b_busy)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   // Scoreboard monitors: pop one expectation per response pulse.
   always @(negedge clk) begin
      if (!rst && a_rvalid) begin
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_resp: got resp_valid=1 required no response");
         end else begin
            ea = qa.pop_front();
            chk("a_resp_rdata", a_rdata, ea.rdata);
            chk1("a_resp_err", a_err, ea.err);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b_rvalid) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_resp: got resp_valid=1 required no response");
         end else begin
            eb = qb.pop_front();
            chk("b_resp_rdata", b_rdata, eb.rdata);
            chk1("b_resp_err", b_err, eb.err);
         end
      end
   end

   // One request on A; checks latency (3 cycles) and busy width (2 cycles).
   task automatic a_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
      int  n;
      int  nbusy;
      bit  seen;
      @(negedge clk);
      chk1("a_ready_idle", a_ready, 1'b1);
      a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
      @(posedge clk);
      qa.push_back('{rdata: exp_rdata, err: exp_err});
      #1 a_valid = 1'b0;
      n = 0; nbusy = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (a_busy) nbusy++;
         if (a_rvalid) seen = 1'b1;
      end
      chk("a_latency", 32'(n), 32'd3);
      chk("a_busy_cycles", 32'(nbusy), 32'd2);
   endtask

   // One accept on B; called just after a negedge, returns just after the
   // next negedge with req_valid still high so calls chain back-to-back.
   task automatic b_step(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
      chk1("b_ready", b_ready, 1'b1);
      b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
      @(posedge clk);
      qb.push_back('{rdata: exp_rdata, err: exp_err});
      @(negedge clk);
      chk1("b_resp_next_cycle", b_rvalid, 1'b1);
      chk1("b_busy_low", b_busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
      b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;

      // Asynchronous reset before any clock edge.
      #3 rst = 1'b1;
      #1;
      chk1("rst_a_ready", a_ready, 1'b1);
      chk1("rst_a_rvalid", a_rvalid, 1'b0);
      chk1("rst_a_busy", a_busy, 1'b0);
      chk("rst_a_rdata", a_rdata, 32'h0);
      chk1("rst_a_err", a_err, 1'b0);
      chk1("rst_b_ready", b_ready, 1'b1);
      chk1("rst_b_rvalid", b_rvalid, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Store then load.
      a_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
      a_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

      // Byte enables.
      a_req(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
      a_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
      a_req(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

      // Errors: misaligned load, out-of-range store aliasing word 0.
      a_req(1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1);
      a_req(1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, 1'b0);
      a_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
      a_req(1'b0, 32'h0, 32'h0, 4'h0, 32'h01020304, 1'b0);
      // Misaligned store and be=0 store leave word 0x10 untouched.
      a_req(1'b1, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
      a_req(1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
      a_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

      // Reset while a load response is being presented.
      @(negedge clk);
      a_valid = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_be = 4'h0;
      @(posedge clk);
      #1 a_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk1("a_rvalid_pre_rst", a_rvalid, 1'b1);
      chk("a_rdata_pre_rst", a_rdata, 32'hDEADBEEF);
      rst = 1'b1;
      #1;
      chk1("midrst_ready", a_ready, 1'b1);
      chk1("midrst_rvalid", a_rvalid, 1'b0);
      chk("midrst_rdata", a_rdata, 32'h0);
      chk1("midrst_busy", a_busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Reset one cycle after accepting a store: store dropped.
      a_req(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
      @(negedge clk);
      a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'h55; a_be = 4'hF;
      @(posedge clk);
      #1 a_valid = 1'b0;
      @(posedge clk);
      #1;
      chk1("wait_busy_pre_rst", a_busy, 1'b1);
      rst = 1'b1;
      #1;
      chk1("waitrst_busy", a_busy, 1'b0);
      chk1("waitrst_ready", a_ready, 1'b1);
      chk1("waitrst_rvalid", a_rvalid, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      a_req(1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

      // Zero wait states: stores then three back-to-back loads.
      @(negedge clk);
      b_step(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
      b_step(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0);
      b_valid = 1'b0;
      @(negedge clk);
      chk1("b_idle_rvalid", b_rvalid, 1'b0);
      b_step(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
      b_step(1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0);
      b_step(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
      b_valid = 1'b0;
      @(negedge clk);
      chk1("b_after_burst_rvalid", b_rvalid, 1'b0);
      chk("b_after_burst_rdata", b_rdata, 32'h0);

      repeat (3) @(negedge clk);
      chk("a_queue_drained", 32'(qa.size()), 32'd0);
      chk("b_queue_drained", 32'(qb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
